// File: rtl/dmem_resp_pkg.sv
// Shared types and widths for the dmem_responder data-memory slave.
package dmem_resp_pkg;

  localparam int WORD_W = 32;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_array.sv
// Single-port word array: synchronous write, registered read, contents never reset.
module dmem_array
  import dmem_resp_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Request/response data-memory slave with a fixed number of wait states.
// Optional misaligned-address rejection is enabled by defining DMEM_RESP_ALIGN_CHECK_EN.
module dmem_responder
  import dmem_resp_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [31:0]       req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [WORD_W-1:0] resp_rdata,
  output logic              resp_err
);

  localparam int ADDR_W = $clog2(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] CNT_LOAD = (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : '0;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              cap_write, cap_err;
  logic [ADDR_W-1:0] cap_idx;
  logic [WORD_W-1:0] cap_wdata;

  logic              accept;
  logic              live_range_err, live_align_err, live_err;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata, mem_rdata;

  assign accept         = (state_q == IDLE) && req_valid;
  assign live_range_err = {2'b00, req_addr[31:2]} >= 32'(DEPTH_WORDS);

`ifdef DMEM_RESP_ALIGN_CHECK_EN
  assign live_align_err = |req_addr[1:0];
`else
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^req_addr[1:0];
  assign live_align_err   = 1'b0;
`endif

  assign live_err = live_range_err | live_align_err;

  // With zero wait states the array is accessed on the acceptance edge itself,
  // so in IDLE the array sees the live request rather than the captured copy.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_en    = 1'b0;
    mem_addr  = cap_idx;
    mem_we    = cap_write;
    mem_wdata = cap_wdata;
    case (state_q)
      IDLE: begin
        mem_addr  = req_addr[ADDR_W+1:2];
        mem_we    = req_write;
        mem_wdata = req_wdata;
        if (req_valid) begin
          if (WAIT_STATES > 0) begin
            state_d = WAIT;
            cnt_d   = CNT_LOAD;
          end else begin
            state_d = RESP;
            mem_en  = !live_err;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          mem_en  = !cap_err;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      cap_write <= 1'b0;
      cap_err   <= 1'b0;
      cap_idx   <= '0;
      cap_wdata <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        cap_write <= req_write;
        cap_err   <= live_err;
        cap_idx   <= req_addr[ADDR_W+1:2];
        cap_wdata <= req_wdata;
      end
    end
  end

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .ADDR_W     (ADDR_W)
  ) u_array (
    .clk  (clk),
    .en   (mem_en),
    .we   (mem_we),
    .addr (mem_addr),
    .wdata(mem_wdata),
    .rdata(mem_rdata)
  );

  // The array read register is only loaded on entry to RESP, so gating it here
  // keeps the response stable while giving 0 for stores, errors and reset.
  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_err   = resp_valid && cap_err;
  assign resp_rdata = (resp_valid && !cap_write && !cap_err) ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench: instance 0 uses two wait states, instance 1 uses none.
module tb_dmem_responder;

`ifdef DMEM_RESP_ALIGN_CHECK_EN
  localparam bit ALIGN_CHK = 1'b1;
`else
  localparam bit ALIGN_CHK = 1'b0;
`endif

  logic             clk = 1'b0;
  logic [1:0]       reset;
  logic [1:0]       req_valid, req_write, req_ready;
  logic [1:0][31:0] req_addr, req_wdata, resp_rdata;
  logic [1:0]       resp_valid, resp_ready, resp_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(2)) u_dut2 (
    .clk(clk), .reset(reset[0]),
    .req_valid(req_valid[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_ready(req_ready[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
  );

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .reset(reset[1]),
    .req_valid(req_valid[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_ready(req_ready[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // One full transaction on instance d: accept, measure latency, optionally stall
  // in RESP for 'hold' cycles while a competing request is offered, then hand shake.
  task automatic applyStimulus(input int d, input logic wr, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] exp_rdata,
                               input logic exp_err, input int exp_lat, input int hold,
                               input string tag);
    int n;
    @(negedge clk);
    req_valid[d]  = 1'b1;
    req_write[d]  = wr;
    req_addr[d]   = addr;
    req_wdata[d]  = wdata;
    resp_ready[d] = 1'b0;
    checkOutput({tag, ".req_ready"}, 32'(req_ready[d]), 32'd1);
    @(negedge clk);
    req_valid[d] = 1'b0;
    req_write[d] = ~wr;
    req_addr[d]  = 32'hFFFF_FFFC;
    req_wdata[d] = 32'h0BAD_0BAD;
    n = 1;
    while (resp_valid[d] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, ".latency"}, 32'(n), 32'(exp_lat));
    checkOutput({tag, ".rdata"}, resp_rdata[d], exp_rdata);
    checkOutput({tag, ".err"}, 32'(resp_err[d]), 32'(exp_err));
    for (int i = 0; i < hold; i++) begin
      req_valid[d] = 1'b1;
      req_write[d] = 1'b1;
      req_addr[d]  = 32'h0000_0010;
      req_wdata[d] = 32'h0000_0000;
      @(negedge clk);
      checkOutput({tag, ".hold_valid"}, 32'(resp_valid[d]), 32'd1);
      checkOutput({tag, ".hold_rdata"}, resp_rdata[d], exp_rdata);
      checkOutput({tag, ".hold_err"}, 32'(resp_err[d]), 32'(exp_err));
      checkOutput({tag, ".hold_ready"}, 32'(req_ready[d]), 32'd0);
    end
    req_valid[d]  = 1'b0;
    resp_ready[d] = 1'b1;
    @(negedge clk);
    resp_ready[d] = 1'b0;
    checkOutput({tag, ".idle_ready"}, 32'(req_ready[d]), 32'd1);
    checkOutput({tag, ".idle_valid"}, 32'(resp_valid[d]), 32'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    logic [31:0] word4_exp;

    reset      = 2'b11;
    req_valid  = '0;
    req_write  = '0;
    req_addr   = '0;
    req_wdata  = '0;
    resp_ready = '0;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checkOutput("reset.req_ready", 32'(req_ready[d]), 32'd1);
      checkOutput("reset.resp_valid", 32'(resp_valid[d]), 32'd0);
      checkOutput("reset.resp_rdata", resp_rdata[d], 32'd0);
      checkOutput("reset.resp_err", 32'(resp_err[d]), 32'd0);
    end
    reset = 2'b00;

    // Two wait states: store then load the same word.
    applyStimulus(0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 3, 0, "ws2_store10");
    applyStimulus(0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 3, 0, "ws2_load10");

    // Zero wait states.
    applyStimulus(1, 1'b1, 32'h0, 32'h12345678, 32'h0, 1'b0, 1, 0, "ws0_store0");
    applyStimulus(1, 1'b0, 32'h0, 32'h0, 32'h12345678, 1'b0, 1, 0, "ws0_load0");

    // Stalled response with a competing store offered; the store must be dropped.
    applyStimulus(0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 3, 5, "ws2_stall");
    applyStimulus(0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 3, 0, "ws2_after_stall");

    // Out-of-range index aliases word 0 in the low bits, so word 0 must survive.
    applyStimulus(0, 1'b1, 32'h0, 32'h11111111, 32'h0, 1'b0, 3, 0, "ws2_store0");
    applyStimulus(0, 1'b1, 32'h400, 32'hCAFEF00D, 32'h0, 1'b1, 3, 0, "ws2_store400");
    applyStimulus(0, 1'b0, 32'h400, 32'h0, 32'h0, 1'b1, 3, 0, "ws2_load400");
    applyStimulus(0, 1'b0, 32'h0, 32'h0, 32'h11111111, 1'b0, 3, 0, "ws2_load0");

    // Misaligned store to byte 0x13 (word 4).
    word4_exp = ALIGN_CHK ? 32'hDEADBEEF : 32'hA5A5A5A5;
    applyStimulus(0, 1'b1, 32'h13, 32'hA5A5A5A5, 32'h0, ALIGN_CHK, 3, 0, "ws2_store13");
    applyStimulus(0, 1'b0, 32'h10, 32'h0, word4_exp, 1'b0, 3, 0, "ws2_load_word4");

    // Last valid word and first invalid word on the zero-wait instance.
    applyStimulus(1, 1'b1, 32'h3FC, 32'h0BADCAFE, 32'h0, 1'b0, 1, 0, "ws0_store3fc");
    applyStimulus(1, 1'b0, 32'h3FC, 32'h0, 32'h0BADCAFE, 1'b0, 1, 0, "ws0_load3fc");
    applyStimulus(1, 1'b0, 32'h400, 32'h0, 32'h0, 1'b1, 1, 0, "ws0_load400");

    // Reset in the middle of a store's wait period discards the store.
    applyStimulus(0, 1'b1, 32'h20, 32'h01020304, 32'h0, 1'b0, 3, 0, "ws2_store20");
    @(negedge clk);
    req_valid[0] = 1'b1;
    req_write[0] = 1'b1;
    req_addr[0]  = 32'h20;
    req_wdata[0] = 32'h99999999;
    @(negedge clk);
    req_valid[0] = 1'b0;
    checkOutput("rst_wait.in_wait_ready", 32'(req_ready[0]), 32'd0);
    checkOutput("rst_wait.in_wait_valid", 32'(resp_valid[0]), 32'd0);
    reset[0] = 1'b1;
    #1;
    checkOutput("rst_wait.req_ready", 32'(req_ready[0]), 32'd1);
    checkOutput("rst_wait.resp_valid", 32'(resp_valid[0]), 32'd0);
    checkOutput("rst_wait.resp_err", 32'(resp_err[0]), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset[0] = 1'b0;
    applyStimulus(0, 1'b0, 32'h20, 32'h0, 32'h01020304, 1'b0, 3, 0, "ws2_load20");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
